// File: rtl/gp_cmd_executor_if.sv
// gp_cmd_executor_if: valid/ready bus port of the GP command executor.
// The master drives the request (valid, address, write data, direction).
// The slave returns ready and read data.
interface gp_cmd_executor_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mst_o_valid;
  logic [ADDR_WIDTH-1:0] mst_o_addr;
  logic [DATA_WIDTH-1:0] mst_o_wr_data;
  logic                  mst_o_rd0_wr1;
  logic                  mst_i_ready;
  logic                  mst_i_rd_valid;
  logic [DATA_WIDTH-1:0] mst_i_rd_data;

  modport master (
    output mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1,
    input  mst_i_ready, mst_i_rd_valid, mst_i_rd_data
  );

  modport slave (
    input  mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1,
    output mst_i_ready, mst_i_rd_valid, mst_i_rd_data
  );
endinterface

// File: rtl/gp_cmd_executor.sv
// gp_cmd_executor: fetches 64-bit commands from the command buffer by index.
// It executes each command as a word-aligned bus WRITE or read-modify-write.
// A sequence is zero or more RWM commands ended by one WRITE command.
// Optional feature macro GP_EXEC_TIMEOUT_EN adds a read-response watchdog
// (TIMEOUT_CYCLES); without it RD_WAIT waits indefinitely.
// All outputs are registered from the next state, so every output reflects
// the state the FSM has just entered.
module gp_cmd_executor #(
  parameter int unsigned CMD_WIDTH      = 64,
  parameter int unsigned CMD_DEPTH      = 128,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic                  cmd_rd_en,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_rd_valid,
  input  logic [CMD_WIDTH-1:0]  cmd_out,
  gp_cmd_executor_if.master     mst
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_CMD = 3'd2;
  localparam logic [2:0] ST_RD_REQ   = 3'd3;
  localparam logic [2:0] ST_RD_WAIT  = 3'd4;
  localparam logic [2:0] ST_WR_REQ   = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  localparam logic [1:0] TYPE_WRITE  = 2'b00;
  localparam logic [1:0] TYPE_SET    = 2'b01;
  localparam logic [1:0] TYPE_CLEAR  = 2'b10;

  localparam logic [1:0] ERR_TYPE    = 2'b01;
  localparam logic [1:0] ERR_NOTERM  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(CMD_DEPTH);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [1:0]            r_type;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [1:0]            r_err_code;
  logic                  r_cmd_rd_en;
  logic                  r_mst_valid;
  logic                  r_rd0_wr1;

  logic [2:0]            w_next_state;
  logic [1:0]            w_next_err;
  logic [ADDR_WIDTH-1:0] w_index_inc;
  logic                  w_timeout;
  logic                  w_start_acc;
  logic                  w_cmd_latch;
  logic                  w_rd_done;

  assign w_index_inc = r_index + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_cmd_latch = (r_state == ST_WAIT_CMD) && cmd_rd_valid;
  assign w_rd_done   = (r_state == ST_RD_WAIT) && mst.mst_i_rd_valid;

`ifdef GP_EXEC_TIMEOUT_EN
  localparam int unsigned LP_TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [LP_TO_W-1:0] r_to_cnt;

  // Watchdog: zero outside RD_WAIT, so it restarts from 0 on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_RD_WAIT) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + {{(LP_TO_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_timeout = (r_to_cnt == LP_TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state decode and the error code to load when entering ERR.
  always_comb begin
    w_next_state = r_state;
    w_next_err   = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_FETCH;
        else       w_next_state = ST_IDLE;
      end
      ST_FETCH: begin
        w_next_state = ST_WAIT_CMD;
      end
      ST_WAIT_CMD: begin
        if (cmd_rd_valid) begin
          case (cmd_out[1:0])
            TYPE_WRITE: w_next_state = ST_WR_REQ;
            TYPE_SET:   w_next_state = ST_RD_REQ;
            TYPE_CLEAR: w_next_state = ST_RD_REQ;
            default: begin
              w_next_state = ST_ERR;
              w_next_err   = ERR_TYPE;
            end
          endcase
        end else begin
          w_next_state = ST_WAIT_CMD;
        end
      end
      ST_RD_REQ: begin
        if (mst.mst_i_ready) w_next_state = ST_RD_WAIT;
        else                 w_next_state = ST_RD_REQ;
      end
      ST_RD_WAIT: begin
        if (mst.mst_i_rd_valid) begin
          w_next_state = ST_WR_REQ;
        end else if (w_timeout) begin
          w_next_state = ST_ERR;
          w_next_err   = ERR_TIMEOUT;
        end else begin
          w_next_state = ST_RD_WAIT;
        end
      end
      ST_WR_REQ: begin
        if (!mst.mst_i_ready) begin
          w_next_state = ST_WR_REQ;
        end else if (r_type == TYPE_WRITE) begin
          w_next_state = ST_DONE;
        end else if (w_index_inc == LP_DEPTH) begin
          w_next_state = ST_ERR;
          w_next_err   = ERR_NOTERM;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      ST_ERR:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, index, status and handshake outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= 2'b00;
      r_cmd_rd_en <= 1'b0;
      r_mst_valid <= 1'b0;
      r_rd0_wr1   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_busy      <= (w_next_state != ST_IDLE);
      r_done      <= (w_next_state == ST_DONE);
      r_error     <= (w_next_state == ST_ERR);
      r_cmd_rd_en <= (w_next_state == ST_FETCH);
      r_mst_valid <= (w_next_state == ST_RD_REQ) || (w_next_state == ST_WR_REQ);
      r_rd0_wr1   <= (w_next_state == ST_WR_REQ);
      if (w_start_acc) begin
        r_index    <= '0;
        r_err_code <= 2'b00;
      end else if (w_next_state == ST_ERR) begin
        r_err_code <= w_next_err;
        if ((r_state == ST_WR_REQ) && mst.mst_i_ready) begin
          r_index <= w_index_inc;
        end
      end else if ((r_state == ST_WR_REQ) && mst.mst_i_ready && (r_type != TYPE_WRITE)) begin
        r_index <= w_index_inc;
      end
    end
  end

  // Command latch and write-data formation; held stable while a request waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_type  <= 2'b00;
      r_data  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_cmd_latch) begin
      r_type  <= cmd_out[1:0];
      r_data  <= DATA_WIDTH'(cmd_out[33:2]);
      r_addr  <= ADDR_WIDTH'({cmd_out[CMD_WIDTH-1:34], 2'b00});
      r_wdata <= DATA_WIDTH'(cmd_out[33:2]);
    end else if (w_rd_done) begin
      if (r_type == TYPE_SET) r_wdata <= mst.mst_i_rd_data | r_data;
      else                    r_wdata <= mst.mst_i_rd_data & ~r_data;
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign error             = r_error;
  assign err_code          = r_err_code;
  assign cmd_rd_en         = r_cmd_rd_en;
  assign cmd_addr          = r_index;
  assign mst.mst_o_valid   = r_mst_valid;
  assign mst.mst_o_addr    = r_addr;
  assign mst.mst_o_wr_data = r_wdata;
  assign mst.mst_o_rd0_wr1 = r_rd0_wr1;

endmodule

// File: tb/tb_gp_cmd_executor.sv
// tb_gp_cmd_executor: directed, table-driven bench for gp_cmd_executor.
// It uses a command-buffer model (one-cycle read latency), a bus slave with
// programmable ready stall and read data, and a monitor that logs bus traffic.
module tb_gp_cmd_executor;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 64;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic          cmd_rd_en;
  logic [AW-1:0] cmd_addr;
  logic          cmd_rd_valid = 1'b0;
  logic [CW-1:0] cmd_out = '0;

  gp_cmd_executor_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  gp_cmd_executor #(
    .CMD_WIDTH(CW), .CMD_DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .cmd_rd_en(cmd_rd_en),
    .cmd_addr(cmd_addr), .cmd_rd_valid(cmd_rd_valid), .cmd_out(cmd_out),
    .mst(bus)
  );

  always #5 clk = ~clk;

  // Command buffer model
  logic [CW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    cmd_rd_valid <= cmd_rd_en;
    cmd_out      <= mem[cmd_addr[6:0]];
  end

  // Bus slave model
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  logic [31:0] rd_value = '0;
  logic        withhold = 1'b0;
  logic        pend = 1'b0;
  logic        rd_valid_q = 1'b0;
  logic [31:0] rd_data_q = '0;

  assign bus.mst_i_ready    = (stall_cnt >= stall_cfg);
  assign bus.mst_i_rd_valid = rd_valid_q;
  assign bus.mst_i_rd_data  = rd_data_q;

  always @(posedge clk) begin
    if (bus.mst_o_valid && !bus.mst_i_ready) stall_cnt <= stall_cnt + 1;
    else                                     stall_cnt <= 0;
  end

  always @(posedge clk) begin
    rd_data_q <= rd_value;
    if (bus.mst_o_valid && bus.mst_i_ready && !bus.mst_o_rd0_wr1) begin
      if (withhold) begin
        pend       <= 1'b1;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= 1'b1;
      end
    end else if (pend && !withhold) begin
      pend       <= 1'b0;
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  // Traffic monitor
  logic [31:0] wr_a [256];
  logic [31:0] wr_d [256];
  logic [31:0] fe_a [256];
  int n_wr = 0, n_rd = 0, n_fe = 0, n_done = 0, n_err = 0;
  logic log_clr = 1'b0;

  always @(posedge clk) begin
    if (log_clr) begin
      n_wr <= 0; n_rd <= 0; n_fe <= 0; n_done <= 0; n_err <= 0;
    end else if (!rst) begin
      if (bus.mst_o_valid && bus.mst_i_ready) begin
        if (bus.mst_o_rd0_wr1) begin
          wr_a[n_wr[7:0]] <= bus.mst_o_addr;
          wr_d[n_wr[7:0]] <= bus.mst_o_wr_data;
          n_wr <= n_wr + 1;
        end else begin
          n_rd <= n_rd + 1;
        end
      end
      if (cmd_rd_en) begin
        fe_a[n_fe[7:0]] <= cmd_addr;
        n_fe <= n_fe + 1;
      end
      if (done)  n_done <= n_done + 1;
      if (error) n_err  <= n_err + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_cmd(input logic [1:0] t, input logic [31:0] a,
                                         input logic [31:0] d);
    return {a[31:2], d, t};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    @(negedge clk); log_clr = 1'b1;
    @(negedge clk); log_clr = 1'b0;
  endtask

  // Returns at the cycle-1 sample point after the start pulse.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("c1_rd_en", 64'(cmd_rd_en), 64'd1);
    chk("c1_index", 64'(cmd_addr), 64'd0);
    chk("c1_busy", 64'(busy), 64'd1);
    chk("c1_errclr", 64'(err_code), 64'd0);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      step(1);
      n++;
    end
    chk("seq_end", 64'(done || error), 64'd1);
  endtask

  // Waits for a request, checks stability across stalled cycles, steps past acceptance.
  task automatic hold_check(input string nm, input logic dir, input logic [31:0] a,
                            input logic [31:0] d, input logic use_d, input int exp_low);
    int g = 0;
    int low = 0;
    while (!bus.mst_o_valid && g < 50) begin
      step(1);
      g++;
    end
    chk({nm, "_valid"}, 64'(bus.mst_o_valid), 64'd1);
    while (bus.mst_o_valid && !bus.mst_i_ready && low < 20) begin
      chk({nm, "_hold_dir"}, 64'(bus.mst_o_rd0_wr1), 64'(dir));
      chk({nm, "_hold_addr"}, 64'(bus.mst_o_addr), 64'(a));
      if (use_d) chk({nm, "_hold_data"}, 64'(bus.mst_o_wr_data), 64'(d));
      step(1);
      low++;
    end
    chk({nm, "_stall_cycles"}, 64'(low), 64'(exp_low));
    chk({nm, "_acc_valid"}, 64'(bus.mst_o_valid), 64'd1);
    chk({nm, "_acc_addr"}, 64'(bus.mst_o_addr), 64'(a));
    step(1);
  endtask

  typedef struct {
    logic [63:0] c0, c1, c2;
    logic [31:0] rdata;
    int          stall;
    int          exp_nfe, exp_nrd, exp_nwr;
    logic [31:0] exp_a0, exp_d0, exp_al, exp_dl;
    logic        exp_done;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{mk_cmd(2'b00, 32'h4000_0010, 32'hA5A5_A5A5), 64'd0, 64'd0, 32'h0, 0,
                1, 0, 1, 32'h4000_0010, 32'hA5A5_A5A5, 32'h4000_0010, 32'hA5A5_A5A5, 1'b1, 2'b00};
    vecs[1] = '{mk_cmd(2'b01, 32'h10, 32'h0000_00F0), mk_cmd(2'b00, 32'h14, 32'h1), 64'd0,
                32'h1234_5600, 0, 2, 1, 2, 32'h10, 32'h1234_56F0, 32'h14, 32'h1, 1'b1, 2'b00};
    vecs[2] = '{mk_cmd(2'b10, 32'h20, 32'h0000_000F), mk_cmd(2'b00, 32'h24, 32'hDEAD), 64'd0,
                32'hFFFF_FFFF, 3, 2, 1, 2, 32'h20, 32'hFFFF_FFF0, 32'h24, 32'hDEAD, 1'b1, 2'b00};
    vecs[3] = '{mk_cmd(2'b01, 32'h100, 32'h1), mk_cmd(2'b10, 32'h104, 32'h0000_F000),
                mk_cmd(2'b11, 32'h108, 32'h0), 32'h0000_FF00, 0, 3, 2, 2,
                32'h100, 32'h0000_FF01, 32'h104, 32'h0000_0F00, 1'b0, 2'b01};
    vecs[4] = '{mk_cmd(2'b11, 32'h50, 32'h0), 64'd0, 64'd0, 32'h0, 0,
                1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01};
    vecs[5] = '{mk_cmd(2'b00, 32'hFFFF_FFFC, 32'h8000_0001), 64'd0, 64'd0, 32'h0, 2,
                1, 0, 1, 32'hFFFF_FFFC, 32'h8000_0001, 32'hFFFF_FFFC, 32'h8000_0001, 1'b1, 2'b00};

    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'd0;
    step(3);

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_rd_en", 64'(cmd_rd_en), 64'd0);
    chk("rst_index", 64'(cmd_addr), 64'd0);
    chk("rst_valid", 64'(bus.mst_o_valid), 64'd0);
    chk("rst_addr", 64'(bus.mst_o_addr), 64'd0);
    rst = 1'b0;
    step(2);

    // Single WRITE cycle-by-cycle timing
    mem[0] = mk_cmd(2'b00, 32'h4000_0010, 32'hA5A5_A5A5);
    clear_logs();
    pulse_start();
    chk("w_c1_valid", 64'(bus.mst_o_valid), 64'd0);
    step(1);
    chk("w_c2_rd_en", 64'(cmd_rd_en), 64'd0);
    chk("w_c2_valid", 64'(bus.mst_o_valid), 64'd0);
    step(1);
    chk("w_c3_valid", 64'(bus.mst_o_valid), 64'd1);
    chk("w_c3_dir", 64'(bus.mst_o_rd0_wr1), 64'd1);
    chk("w_c3_addr", 64'(bus.mst_o_addr), 64'h4000_0010);
    chk("w_c3_data", 64'(bus.mst_o_wr_data), 64'hA5A5_A5A5);
    chk("w_c3_done", 64'(done), 64'd0);
    step(1);
    chk("w_c4_done", 64'(done), 64'd1);
    chk("w_c4_valid", 64'(bus.mst_o_valid), 64'd0);
    chk("w_c4_busy", 64'(busy), 64'd1);
    step(1);
    chk("w_c5_done", 64'(done), 64'd0);
    chk("w_c5_busy", 64'(busy), 64'd0);

    // RWM-set then WRITE timing
    mem[0] = mk_cmd(2'b01, 32'h10, 32'h0000_00F0);
    mem[1] = mk_cmd(2'b00, 32'h14, 32'h1);
    rd_value = 32'h1234_5600;
    clear_logs();
    pulse_start();
    step(2);
    chk("r_c3_valid", 64'(bus.mst_o_valid), 64'd1);
    chk("r_c3_dir", 64'(bus.mst_o_rd0_wr1), 64'd0);
    chk("r_c3_addr", 64'(bus.mst_o_addr), 64'h10);
    step(1);
    chk("r_c4_valid", 64'(bus.mst_o_valid), 64'd0);
    step(1);
    chk("r_c5_valid", 64'(bus.mst_o_valid), 64'd1);
    chk("r_c5_dir", 64'(bus.mst_o_rd0_wr1), 64'd1);
    chk("r_c5_data", 64'(bus.mst_o_wr_data), 64'h1234_56F0);
    step(1);
    chk("r_c6_rd_en", 64'(cmd_rd_en), 64'd1);
    chk("r_c6_index", 64'(cmd_addr), 64'd1);
    wait_end(100);
    chk("r_done", 64'(done), 64'd1);

    // Stalled ready: request held stable
    mem[0] = mk_cmd(2'b10, 32'h20, 32'h0000_000F);
    mem[1] = mk_cmd(2'b00, 32'h24, 32'hDEAD);
    rd_value = 32'hFFFF_FFFF;
    stall_cfg = 3;
    clear_logs();
    pulse_start();
    hold_check("stall_rd", 1'b0, 32'h20, 32'h0, 1'b0, 3);
    hold_check("stall_wr", 1'b1, 32'h20, 32'hFFFF_FFF0, 1'b1, 3);
    wait_end(100);
    stall_cfg = 0;
    step(2);

    // Table-driven sequences
    for (int i = 0; i < 6; i++) begin
      mem[0] = vecs[i].c0;
      mem[1] = vecs[i].c1;
      mem[2] = vecs[i].c2;
      rd_value = vecs[i].rdata;
      stall_cfg = vecs[i].stall;
      clear_logs();
      pulse_start();
      wait_end(300);
      chk($sformatf("v%0d_code", i), 64'(err_code), 64'(vecs[i].exp_code));
      step(1);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      chk($sformatf("v%0d_ndone", i), 64'(n_done), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_nerr", i), 64'(n_err), 64'(!vecs[i].exp_done));
      chk($sformatf("v%0d_nfetch", i), 64'(n_fe), 64'(vecs[i].exp_nfe));
      chk($sformatf("v%0d_last_idx", i), 64'(fe_a[vecs[i].exp_nfe-1]), 64'(vecs[i].exp_nfe-1));
      chk($sformatf("v%0d_nrd", i), 64'(n_rd), 64'(vecs[i].exp_nrd));
      chk($sformatf("v%0d_nwr", i), 64'(n_wr), 64'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr > 0) begin
        chk($sformatf("v%0d_a0", i), 64'(wr_a[0]), 64'(vecs[i].exp_a0));
        chk($sformatf("v%0d_d0", i), 64'(wr_d[0]), 64'(vecs[i].exp_d0));
        chk($sformatf("v%0d_alast", i), 64'(wr_a[vecs[i].exp_nwr-1]), 64'(vecs[i].exp_al));
        chk($sformatf("v%0d_dlast", i), 64'(wr_d[vecs[i].exp_nwr-1]), 64'(vecs[i].exp_dl));
      end
    end
    stall_cfg = 0;

    // 128 RWMs without terminator
    for (int i = 0; i < DEPTH; i++) mem[i] = mk_cmd(2'b01, 32'h1000 + 32'(4 * i), 32'(i));
    rd_value = 32'h0;
    clear_logs();
    pulse_start();
    wait_end(2000);
    chk("nt_error", 64'(error), 64'd1);
    chk("nt_code", 64'(err_code), 64'd2);
    chk("nt_nwr_at_err", 64'(n_wr), 64'd128);
    step(1);
    chk("nt_nrd", 64'(n_rd), 64'd128);
    chk("nt_nfetch", 64'(n_fe), 64'd128);
    chk("nt_last_idx", 64'(fe_a[127]), 64'd127);
    chk("nt_last_addr", 64'(wr_a[127]), 64'h11FC);
    chk("nt_last_data", 64'(wr_d[127]), 64'd127);
    chk("nt_ndone", 64'(n_done), 64'd0);

    // Read data withheld
    begin
      int g = 0;
      mem[0] = mk_cmd(2'b01, 32'h30, 32'h3);
      mem[1] = mk_cmd(2'b00, 32'h34, 32'h7);
      rd_value = 32'h10;
      withhold = 1'b1;
      clear_logs();
      pulse_start();
      while (!(bus.mst_o_valid && !bus.mst_o_rd0_wr1) && g < 50) begin
        step(1);
        g++;
      end
      chk("wd_rd_req", 64'(bus.mst_o_valid && !bus.mst_o_rd0_wr1), 64'd1);
`ifdef GP_EXEC_TIMEOUT_EN
      step(8);
      chk("to_before_err", 64'(error), 64'd0);
      chk("to_before_busy", 64'(busy), 64'd1);
      step(1);
      chk("to_error", 64'(error), 64'd1);
      chk("to_code", 64'(err_code), 64'd3);
      withhold = 1'b0;
      step(4);
      chk("to_ndone", 64'(n_done), 64'd0);
      chk("to_busy_after", 64'(busy), 64'd0);
`else
      step(40);
      chk("wd_nerr", 64'(n_err), 64'd0);
      chk("wd_busy", 64'(busy), 64'd1);
      chk("wd_valid", 64'(bus.mst_o_valid), 64'd0);
      withhold = 1'b0;
      wait_end(50);
      chk("wd_done", 64'(done), 64'd1);
      chk("wd_a0", 64'(wr_a[0]), 64'h30);
      chk("wd_d0", 64'(wr_d[0]), 64'h13);
`endif
      step(2);
    end

    // Reset during WR_REQ, then restart
    begin
      int g = 0;
      mem[0] = mk_cmd(2'b01, 32'h40, 32'h1);
      mem[1] = mk_cmd(2'b00, 32'h44, 32'h55);
      rd_value = 32'h0;
      stall_cfg = 5;
      clear_logs();
      pulse_start();
      while (!(bus.mst_o_valid && bus.mst_o_rd0_wr1 && bus.mst_o_addr == 32'h44) && g < 300) begin
        step(1);
        g++;
      end
      chk("rs_in_wr_req", 64'(cmd_addr), 64'd1);
      rst = 1'b1;
      step(1);
      chk("rs_busy", 64'(busy), 64'd0);
      chk("rs_done", 64'(done), 64'd0);
      chk("rs_error", 64'(error), 64'd0);
      chk("rs_code", 64'(err_code), 64'd0);
      chk("rs_rd_en", 64'(cmd_rd_en), 64'd0);
      chk("rs_index", 64'(cmd_addr), 64'd0);
      chk("rs_valid", 64'(bus.mst_o_valid), 64'd0);
      chk("rs_addr", 64'(bus.mst_o_addr), 64'd0);
      chk("rs_wdata", 64'(bus.mst_o_wr_data), 64'd0);
      chk("rs_dir", 64'(bus.mst_o_rd0_wr1), 64'd0);
      rst = 1'b0;
      step(3);
      chk("rs_ndone", 64'(n_done), 64'd0);
      chk("rs_nerr", 64'(n_err), 64'd0);
      stall_cfg = 0;
      clear_logs();
      pulse_start();
      wait_end(100);
      chk("rs2_done", 64'(done), 64'd1);
      step(1);
      chk("rs2_nwr", 64'(n_wr), 64'd2);
      chk("rs2_a0", 64'(wr_a[0]), 64'h40);
      chk("rs2_d0", 64'(wr_d[0]), 64'h1);
      chk("rs2_d1", 64'(wr_d[1]), 64'h55);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gp_cmd_executor.md
# gp_cmd_executor

Command execution engine of the GP engine, sitting directly downstream of the command buffer. On a start pulse it fetches 64-bit commands by index from the buffer, decodes them, and performs the resulting word-aligned bus write or read-modify-write through a valid/ready bus-master port. A sequence is any number of RWM commands terminated by one WRITE command. Completion and error are reported to the control/status logic.

## Interface
- `CMD_WIDTH`, default 64: command width; field layout is fixed for 64.
- `CMD_DEPTH`, default 128: number of command-buffer entries.
- `ADDR_WIDTH`, default 32: bus and command-index width.
- `DATA_WIDTH`, default 32: bus data width.
- `TIMEOUT_CYCLES`, default 256: read-response watchdog limit; used only with `GP_EXEC_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; the block has one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  single-cycle pulse that starts a sequence; ignored unless IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE/ERR is left.
- `done`  out  1  one-cycle pulse when the terminating WRITE is accepted.
- `error`  out  1  one-cycle pulse on abort.
- `err_code`  out  2  01 = bad type, 10 = no terminator, 11 = timeout; held until next `start`.
- `cmd_rd_en`  out  1  fetch strobe to the command buffer.
- `cmd_addr`  out  ADDR_WIDTH  entry index (not byte address).
- `cmd_rd_valid`  in  1  fetch data valid.
- `cmd_out`  in  CMD_WIDTH  fetched command.
- `mst_o_valid`  out  1  bus request valid.
- `mst_o_addr`  out  ADDR_WIDTH  bus address.
- `mst_o_wr_data`  out  DATA_WIDTH  bus write data.
- `mst_o_rd0_wr1`  out  1  1 = write, 0 = read.
- `mst_i_ready`  in  1  bus accepts the request.
- `mst_i_rd_valid`  in  1  read data valid.
- `mst_i_rd_data`  in  DATA_WIDTH  read data.

## Operation
- Command fields:
  - `[1:0]` type: 00 WRITE, 01 RWM-set, 10 RWM-clear, 11 illegal.
  - `[33:2]` data.
  - `[63:34]` address word bits; bus address = {cmd[63:34], 2'b00}.
- States: IDLE, FETCH, WAIT_CMD, RD_REQ, RD_WAIT, WR_REQ, DONE, ERR.
- IDLE: on `start`, clear the index to 0 and go to FETCH.
- FETCH: assert `cmd_rd_en` for one cycle with `cmd_addr` = index; go to WAIT_CMD.
- WAIT_CMD: on `cmd_rd_valid`, latch `cmd_out`, then:
  - type 00 goes to WR_REQ with wdata = data.
  - type 01/10 goes to RD_REQ.
  - type 11 goes to ERR with code 01.
- RD_REQ: `mst_o_valid`=1, `rd0_wr1`=0. On `mst_i_ready`, go to RD_WAIT.
- RD_WAIT: on `mst_i_rd_valid`, compute wdata:
  - RWM-set: rd_data | data.
  - RWM-clear: rd_data & ~data.
  - Then go to WR_REQ.
- WR_REQ: `mst_o_valid`=1, `rd0_wr1`=1. On `mst_i_ready`:
  - WRITE goes to DONE.
  - RWM increments the index. If the new index == CMD_DEPTH, go to ERR with code 10; otherwise go to FETCH.
- DONE: pulse `done` and go to IDLE. ERR: pulse `error` and go to IDLE.
- Bus rule: while `mst_o_valid`=1 and `mst_i_ready`=0, address, data and direction stay stable. Valid is never withdrawn before acceptance.
- `mst_i_rd_valid` outside RD_WAIT is ignored. `start` while not IDLE is ignored.
- Reset values: all outputs 0; state IDLE; index 0; `err_code` 00.
- Reset mid-sequence: return to IDLE at the next edge. An outstanding request is dropped and no `done`/`error` pulse is produced.

## Timing
- All outputs are registered.
- `start` sampled at cycle 0 gives `cmd_rd_en` at cycle 1 and the latched command at cycle 2.
- WRITE with `mst_i_ready` already high: `mst_o_valid` at cycle 3, `done` at cycle 4.
- RWM with zero-wait ready and read data one cycle after acceptance: read request at cycle 3, `rd_valid` at cycle 4, write request at cycle 5, next FETCH at cycle 6.
- Each ready or read-data wait cycle adds exactly one cycle.
- `busy` rises at cycle 1 and falls in the cycle after `done`/`error`.

## Configuration
- `GP_EXEC_TIMEOUT_EN` defined:
  - A counter clears on entry to RD_WAIT and increments each cycle in it.
  - At TIMEOUT_CYCLES without `mst_i_rd_valid`, go to ERR with code 11.
- Not defined: no counter; RD_WAIT waits indefinitely.

## Test plan
- Single WRITE {addr 0x4000_0010, data 0xA5A5_A5A5} at entry 0, ready tied high -> one write to 0x4000_0010 with 0xA5A5_A5A5; `done` at cycle 4.
- RWM-set data 0x0000_00F0 at 0x10, then WRITE 0x1 at 0x14; read returns 0x1234_5600 -> write 0x1234_56F0 to 0x10, then 0x1 to 0x14; `cmd_addr` 0 then 1; one `done`.
- RWM-clear data 0x0000_000F, read returns 0xFFFF_FFFF, ready low for 3 cycles -> outputs stable for those 3 cycles; write 0xFFFF_FFF0.
- Type 11 at entry 2 -> `error` pulse, `err_code`=01, no bus request for entry 2. 128 RWMs with no WRITE -> `err_code`=10 after the 128th write.
- With `GP_EXEC_TIMEOUT_EN` and TIMEOUT_CYCLES=8, read data withheld -> `error` with `err_code`=11 eight cycles after RD_WAIT entry. Without the macro -> remains in RD_WAIT.
- Assert `rst` during WR_REQ -> next cycle all outputs 0, state IDLE, no `done`; a subsequent `start` restarts at index 0.
